// File: rtl/led_pkg.sv
// Shared types and constants for the RGB LED scheduler: FSM states, source codes, colours.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITEM = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [1:0] SRC_IDLE = 2'd0;
    localparam logic [1:0] SRC_ITEM = 2'd1;
    localparam logic [1:0] SRC_HIT  = 2'd2;
    localparam logic [1:0] SRC_OVER = 2'd3;

    // Colours packed as {R[3:0], G[3:0], B[3:0]}
    localparam logic [11:0] COL_GREEN = 12'h0F0;
    localparam logic [11:0] COL_RED   = 12'hF00;
    localparam logic [11:0] COL_BLUE  = 12'h00F;
    localparam logic [11:0] COL_OFF   = 12'h000;

    function automatic logic [1:0] src_of(input state_t s);
        case (s)
            ITEM:    src_of = SRC_ITEM;
            HIT:     src_of = SRC_HIT;
            OVER:    src_of = SRC_OVER;
            default: src_of = SRC_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/led_episode_timer.sv
// Episode counter: clears on restart, otherwise counts while enabled and wraps to 0 at term.
// at_term flags count == term; wrap pulses on the enabled cycle that returns the count to 0.
module led_episode_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic             at_term,
    output logic             wrap
);

    logic [CNT_W-1:0] count;

    assign at_term = (count == term);
    assign wrap    = enable && !restart && at_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable) begin
            count <= at_term ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/color_led_scheduler.sv
// Fixed-priority owner of the RGB LED: game_over > hit > item, with one deferred item flash.
// All outputs are registered from the next-state decode, so a sampled event shows the following cycle.
module color_led_scheduler
    import led_pkg::*;
#(
    parameter int FLASH_CYCLES = 1000000,
    parameter int BLINK_HALF   = 25000000,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic       item,
    input  logic       game_over,
    output logic [3:0] RED,
    output logic [3:0] GREEN,
    output logic [3:0] BLUE,
    output logic       busy,
    output logic [1:0] src
);

    localparam logic [CNT_W-1:0] FLASH_TERM = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_TERM = CNT_W'(BLINK_HALF - 1);

    state_t      state, nxt;
    logic        item_pend, pend_nxt;
    logic        blink_phase, phase_nxt;
    logic        restart, enable;
    logic        at_term, wrap;
    logic [CNT_W-1:0] term;
    logic [11:0] col_nxt;

    // The one counter serves both the flash length and the blink half-period.
    assign term = (state == OVER) ? BLINK_TERM : FLASH_TERM;

    led_episode_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .enable  (enable),
        .term    (term),
        .at_term (at_term),
        .wrap    (wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            item_pend   <= 1'b0;
            blink_phase <= 1'b0;
        end else begin
            state       <= nxt;
            item_pend   <= pend_nxt;
            blink_phase <= phase_nxt;
        end
    end

    always_comb begin
        nxt       = state;
        pend_nxt  = item_pend;
        phase_nxt = blink_phase;
        restart   = 1'b0;
        enable    = 1'b0;

        if (game_over && state != OVER) begin
            nxt       = OVER;
            restart   = 1'b1;
            pend_nxt  = 1'b0;
            phase_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        nxt      = HIT;
                        restart  = 1'b1;
                        pend_nxt = item;
                    end else if (item) begin
                        nxt     = ITEM;
                        restart = 1'b1;
                    end
                end
                HIT: begin
                    if (item) pend_nxt = 1'b1;
                    if (hit) begin
                        restart = 1'b1;
                    end else if (at_term) begin
                        restart = 1'b1;
                        // An item arriving on the expiry cycle still earns its deferred flash.
                        if (item_pend || item) begin
                            nxt      = ITEM;
                            pend_nxt = 1'b0;
                        end else begin
                            nxt = IDLE;
                        end
                    end else begin
                        enable = 1'b1;
                    end
                end
                ITEM: begin
                    if (hit) begin
                        nxt      = HIT;
                        restart  = 1'b1;
                        pend_nxt = item;
                    end else if (item) begin
                        restart = 1'b1;
                    end else if (at_term) begin
                        nxt     = IDLE;
                        restart = 1'b1;
                    end else begin
                        enable = 1'b1;
                    end
                end
                OVER: begin
                    enable   = 1'b1;
                    pend_nxt = 1'b0;
                    if (wrap) phase_nxt = !blink_phase;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        col_nxt = COL_GREEN;
        case (nxt)
            ITEM:    col_nxt = COL_BLUE;
            HIT:     col_nxt = COL_RED;
            OVER:    col_nxt = phase_nxt ? COL_OFF : COL_RED;
            default: col_nxt = COL_GREEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RED   <= COL_GREEN[11:8];
            GREEN <= COL_GREEN[7:4];
            BLUE  <= COL_GREEN[3:0];
            busy  <= 1'b0;
            src   <= SRC_IDLE;
        end else begin
            RED   <= col_nxt[11:8];
            GREEN <= col_nxt[7:4];
            BLUE  <= col_nxt[3:0];
            busy  <= (nxt != IDLE);
            src   <= src_of(nxt);
        end
    end

endmodule

// File: tb/tb_color_led_scheduler.sv
// Directed-vector bench for color_led_scheduler with FLASH_CYCLES=8, BLINK_HALF=4.
module tb_color_led_scheduler;
    import led_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hit = 1'b0;
    logic       item = 1'b0;
    logic       game_over = 1'b0;
    logic [3:0] red, green, blue;
    logic       busy;
    logic [1:0] src;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    color_led_scheduler #(
        .FLASH_CYCLES (8),
        .BLINK_HALF   (4),
        .CNT_W        (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hit       (hit),
        .item      (item),
        .game_over (game_over),
        .RED       (red),
        .GREEN     (green),
        .BLUE      (blue),
        .busy      (busy),
        .src       (src)
    );

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got {rgb,busy,src}=%h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic stim_hit(input int t, input int c);
        case (t)
            1, 2, 6: return c == 10;
            3:       return c == 12;
            4:       return c == 10 || c == 15;
            5:       return c == 10 || c == 20;
            7:       return c == 10 || c == 18;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic stim_item(input int t, input int c);
        case (t)
            2:       return c == 13;
            3:       return c == 10;
            5:       return c == 22;
            6:       return c == 10 || c == 12 || c == 14;
            8:       return c == 10 || c == 14;
            default: return 1'b0;
        endcase
    endfunction

    // Hand-derived source per cycle: an input driven in cycle c shows from cycle c+1.
    function automatic logic [1:0] exp_src(input int t, input int c);
        case (t)
            1: return (c >= 11 && c <= 18) ? 2'd2 : 2'd0;
            2, 6: begin
                if (c >= 11 && c <= 18) return 2'd2;
                if (c >= 19 && c <= 26) return 2'd1;
                return 2'd0;
            end
            3: begin
                if (c >= 11 && c <= 12) return 2'd1;
                if (c >= 13 && c <= 20) return 2'd2;
                return 2'd0;
            end
            4: return (c >= 11 && c <= 23) ? 2'd2 : 2'd0;
            5: begin
                if (c >= 13) return 2'd3;
                if (c >= 11) return 2'd2;
                return 2'd0;
            end
            7: return (c >= 11 && c <= 26) ? 2'd2 : 2'd0;
            8: return (c >= 11 && c <= 22) ? 2'd1 : 2'd0;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [14:0] exp_vec(input int t, input int c);
        logic [1:0]  s;
        logic [11:0] col;
        s = exp_src(t, c);
        case (s)
            2'd1:    col = 12'h00F;
            2'd2:    col = 12'hF00;
            2'd3:    col = ((((c - 13) / 4) % 2) == 0) ? 12'hF00 : 12'h000;
            default: col = 12'h0F0;
        endcase
        return {col, (s != 2'd0), s};
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        hit       = 1'b0;
        item      = 1'b0;
        game_over = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int t = 1; t <= 8; t++) begin
            int ncyc;
            ncyc = (t == 5) ? 40 : 31;
            do_reset();
            for (int c = 0; c < ncyc; c++) begin
                chk($sformatf("t%0d_c%0d", t, c), {red, green, blue, busy, src}, exp_vec(t, c));
                hit       = stim_hit(t, c);
                item      = stim_item(t, c);
                game_over = (t == 5) && (c >= 12);
                @(posedge clk);
                #1;
            end
            hit  = 1'b0;
            item = 1'b0;
            if (t == 5) begin
                chk("t5_c40", {red, green, blue, busy, src}, exp_vec(5, 40));
                rst = 1'b1;
                #1;
                chk("t5_async_rst", {red, green, blue, busy, src}, {12'h0F0, 1'b0, 2'd0});
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
